// File: rtl/procyon_types.sv
// Shared LSU types: address/tag/function/LQ-select fields, arbitration source encoding.
package procyon_types;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned TAG_W      = 6;
    localparam int unsigned LSU_FUNC_W = 4;
    localparam int unsigned LQ_DEPTH   = 8;

    typedef logic [ADDR_W-1:0]     procyon_addr_t;
    typedef logic [TAG_W-1:0]      procyon_tag_t;
    typedef logic [LSU_FUNC_W-1:0] procyon_lsu_func_t;
    typedef logic [LQ_DEPTH-1:0]   procyon_lq_select_t;

    typedef enum logic [1:0] {
        LSU_SRC_NONE   = 2'd0,
        LSU_SRC_RETIRE = 2'd1,
        LSU_SRC_REPLAY = 2'd2,
        LSU_SRC_NEW    = 2'd3
    } lsu_src_t;

    typedef struct packed {
        procyon_addr_t      addr;
        procyon_tag_t       tag;
        procyon_lsu_func_t  lsu_func;
        procyon_lq_select_t lq_select;
    } lsu_op_t;

endpackage

// File: rtl/lsu_arb_starve.sv
// Counts consecutive cycles a pending new op loses arbitration; flags override at the limit.
module lsu_arb_starve #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_ex_stall,
    input  logic i_new_valid,
    input  logic i_new_grant,
    output logic o_override
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Stalled cycles neither count as losses nor reset the streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_flush || !i_new_valid || i_new_grant) begin
            starve_cnt <= '0;
        end else if (!i_ex_stall && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign o_override = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/lsu_arb.sv
// LSU front-end arbiter: picks one of retire/replay/new per cycle and registers it into LSU_EX.
module lsu_arb
    import procyon_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_ex_stall,

    input  logic               i_retire_valid,
    input  procyon_addr_t      i_retire_addr,
    input  procyon_tag_t       i_retire_tag,
    input  procyon_lsu_func_t  i_retire_lsu_func,
    output logic               o_retire_stall,

    input  logic               i_replay_valid,
    input  procyon_addr_t      i_replay_addr,
    input  procyon_tag_t       i_replay_tag,
    input  procyon_lsu_func_t  i_replay_lsu_func,
    input  procyon_lq_select_t i_replay_lq_select,
    output logic               o_replay_stall,

    input  logic               i_new_valid,
    input  procyon_addr_t      i_new_addr,
    input  procyon_tag_t       i_new_tag,
    input  procyon_lsu_func_t  i_new_lsu_func,
    input  procyon_lq_select_t i_new_lq_select,
    output logic               o_new_stall,

    output logic               o_ex_valid,
    output lsu_src_t           o_ex_src,
    output procyon_addr_t      o_ex_addr,
    output procyon_tag_t       o_ex_tag,
    output procyon_lsu_func_t  o_ex_lsu_func,
    output procyon_lq_select_t o_ex_lq_select
);

    logic     arb_en;
    logic     starve_override;
    logic     retire_gnt;
    logic     replay_gnt;
    logic     new_gnt;
    lsu_src_t win_src;
    lsu_op_t  win_op;
    lsu_op_t  ex_op;

    lsu_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_ex_stall  (i_ex_stall),
        .i_new_valid (i_new_valid),
        .i_new_grant (new_gnt),
        .o_override  (starve_override)
    );

    // Retire always wins; a starved new op jumps ahead of replay; flush kills replay/new.
    assign arb_en     = !rst && !i_ex_stall;
    assign retire_gnt = arb_en && i_retire_valid;
    assign replay_gnt = arb_en && !i_flush && !i_retire_valid && i_replay_valid
                        && !(starve_override && i_new_valid);
    assign new_gnt    = arb_en && !i_flush && !i_retire_valid && i_new_valid
                        && (starve_override || !i_replay_valid);

    assign o_retire_stall = i_retire_valid && !retire_gnt;
    assign o_replay_stall = i_replay_valid && !replay_gnt;
    assign o_new_stall    = i_new_valid && !new_gnt;

    always_comb begin
        win_src = LSU_SRC_NONE;
        win_op  = '0;
        if (retire_gnt) begin
            win_src = LSU_SRC_RETIRE;
            win_op  = '{addr: i_retire_addr, tag: i_retire_tag,
                        lsu_func: i_retire_lsu_func, lq_select: '0};
        end else if (replay_gnt) begin
            win_src = LSU_SRC_REPLAY;
            win_op  = '{addr: i_replay_addr, tag: i_replay_tag,
                        lsu_func: i_replay_lsu_func, lq_select: i_replay_lq_select};
        end else if (new_gnt) begin
            win_src = LSU_SRC_NEW;
            win_op  = '{addr: i_new_addr, tag: i_new_tag,
                        lsu_func: i_new_lsu_func, lq_select: i_new_lq_select};
        end
    end

    // While LSU_EX stalls the held op survives, except a non-retire op hit by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ex_valid <= 1'b0;
            o_ex_src   <= LSU_SRC_NONE;
            ex_op      <= '0;
        end else if (i_ex_stall) begin
            if (i_flush && (o_ex_src != LSU_SRC_RETIRE)) begin
                o_ex_valid <= 1'b0;
                o_ex_src   <= LSU_SRC_NONE;
            end
        end else begin
            o_ex_valid <= (win_src != LSU_SRC_NONE);
            o_ex_src   <= win_src;
            if (win_src != LSU_SRC_NONE) begin
                ex_op <= win_op;
            end
        end
    end

    assign o_ex_addr      = ex_op.addr;
    assign o_ex_tag       = ex_op.tag;
    assign o_ex_lsu_func  = ex_op.lsu_func;
    assign o_ex_lq_select = ex_op.lq_select;

endmodule

// File: tb/tb_lsu_arb.sv
// Self-checking bench for lsu_arb: directed arbitration/stall/flush/reset sequences with a scoreboard.
module tb_lsu_arb;
    import procyon_types::*;

    logic               clk;
    logic               rst;
    logic               i_flush;
    logic               i_ex_stall;
    logic               i_retire_valid;
    procyon_addr_t      i_retire_addr;
    procyon_tag_t       i_retire_tag;
    procyon_lsu_func_t  i_retire_lsu_func;
    logic               o_retire_stall;
    logic               i_replay_valid;
    procyon_addr_t      i_replay_addr;
    procyon_tag_t       i_replay_tag;
    procyon_lsu_func_t  i_replay_lsu_func;
    procyon_lq_select_t i_replay_lq_select;
    logic               o_replay_stall;
    logic               i_new_valid;
    procyon_addr_t      i_new_addr;
    procyon_tag_t       i_new_tag;
    procyon_lsu_func_t  i_new_lsu_func;
    procyon_lq_select_t i_new_lq_select;
    logic               o_new_stall;
    logic               o_ex_valid;
    lsu_src_t           o_ex_src;
    procyon_addr_t      o_ex_addr;
    procyon_tag_t       o_ex_tag;
    procyon_lsu_func_t  o_ex_lsu_func;
    procyon_lq_select_t o_ex_lq_select;

    lsu_arb #(.STARVE_LIMIT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_flush            (i_flush),
        .i_ex_stall         (i_ex_stall),
        .i_retire_valid     (i_retire_valid),
        .i_retire_addr      (i_retire_addr),
        .i_retire_tag       (i_retire_tag),
        .i_retire_lsu_func  (i_retire_lsu_func),
        .o_retire_stall     (o_retire_stall),
        .i_replay_valid     (i_replay_valid),
        .i_replay_addr      (i_replay_addr),
        .i_replay_tag       (i_replay_tag),
        .i_replay_lsu_func  (i_replay_lsu_func),
        .i_replay_lq_select (i_replay_lq_select),
        .o_replay_stall     (o_replay_stall),
        .i_new_valid        (i_new_valid),
        .i_new_addr         (i_new_addr),
        .i_new_tag          (i_new_tag),
        .i_new_lsu_func     (i_new_lsu_func),
        .i_new_lq_select    (i_new_lq_select),
        .o_new_stall        (o_new_stall),
        .o_ex_valid         (o_ex_valid),
        .o_ex_src           (o_ex_src),
        .o_ex_addr          (o_ex_addr),
        .o_ex_tag           (o_ex_tag),
        .o_ex_lsu_func      (o_ex_lsu_func),
        .o_ex_lq_select     (o_ex_lq_select)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  src;
        logic [31:0] addr;
        logic [5:0]  tag;
        logic [7:0]  lq;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   seq      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] addr_of(input logic [1:0] src, input int s);
        logic [31:0] base;
        base = {2'b00, src, 28'h0};
        return base | 32'(s);
    endfunction

    function automatic logic [5:0] tag_of(input logic [1:0] src, input int s);
        logic [31:0] sv;
        sv = 32'(s);
        return {src, sv[3:0]};
    endfunction

    function automatic logic [7:0] lq_of(input logic [1:0] src, input int s);
        if (src == 2'd1) return 8'h00;
        return 8'(8'h1 << (s % 8));
    endfunction

    task automatic step(input string name, input logic rv, input logic pv, input logic nv,
                        input logic fl, input logic exs, input logic [1:0] esrc,
                        input logic [2:0] estall);
        exp_t e;
        seq++;
        i_retire_valid     = rv;
        i_replay_valid     = pv;
        i_new_valid        = nv;
        i_flush            = fl;
        i_ex_stall         = exs;
        i_retire_addr      = addr_of(2'd1, seq);
        i_retire_tag       = tag_of(2'd1, seq);
        i_retire_lsu_func  = 4'(seq);
        i_replay_addr      = addr_of(2'd2, seq);
        i_replay_tag       = tag_of(2'd2, seq);
        i_replay_lsu_func  = 4'(seq + 1);
        i_replay_lq_select = lq_of(2'd2, seq);
        i_new_addr         = addr_of(2'd3, seq);
        i_new_tag          = tag_of(2'd3, seq);
        i_new_lsu_func     = 4'(seq + 2);
        i_new_lq_select    = lq_of(2'd3, seq);
        #1;
        check({name, ".stall"}, {29'b0, o_retire_stall, o_replay_stall, o_new_stall},
              {29'b0, estall});
        if (exs) begin
            e = last_exp;
        end else begin
            e.addr = addr_of(esrc, seq);
            e.tag  = tag_of(esrc, seq);
            e.lq   = lq_of(esrc, seq);
        end
        e.src      = esrc;
        e.valid    = (esrc != 2'd0);
        e.chk_data = e.valid;
        sb_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({name, ".valid"}, 32'(o_ex_valid), 32'(e.valid));
        check({name, ".src"}, 32'(o_ex_src), 32'(e.src));
        if (e.chk_data) begin
            check({name, ".addr"}, o_ex_addr, e.addr);
            check({name, ".tag"}, 32'(o_ex_tag), 32'(e.tag));
            check({name, ".lq"}, 32'(o_ex_lq_select), 32'(e.lq));
        end
    endtask

    task automatic check_cnt(input string name, input int exp);
        check({name, ".cnt"}, 32'(dut.u_starve.starve_cnt), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        i_ex_stall = 1'b0;
        i_retire_valid = 1'b1;
        i_replay_valid = 1'b1;
        i_new_valid = 1'b1;
        i_retire_addr = '0; i_retire_tag = '0; i_retire_lsu_func = '0;
        i_replay_addr = '0; i_replay_tag = '0; i_replay_lsu_func = '0; i_replay_lq_select = '0;
        i_new_addr = '0; i_new_tag = '0; i_new_lsu_func = '0; i_new_lq_select = '0;
        last_exp = '{valid: 1'b0, src: 2'd0, addr: 32'h0, tag: 6'h0, lq: 8'h0, chk_data: 1'b0};
        #1;
        check("rst.stall", {29'b0, o_retire_stall, o_replay_stall, o_new_stall}, 32'h7);
        @(posedge clk);
        #1;
        check("rst.valid", 32'(o_ex_valid), 32'h0);
        check("rst.src", 32'(o_ex_src), 32'h0);
        check("rst.addr", o_ex_addr, 32'h0);
        check("rst.tag", 32'(o_ex_tag), 32'h0);
        check_cnt("rst", 0);
        rst = 1'b0;

        step("prio_all", 1, 1, 1, 0, 0, 2'd1, 3'b011);
        check_cnt("prio_all", 1);
        step("idle0", 0, 0, 0, 0, 0, 2'd0, 3'b000);
        check_cnt("idle0", 0);

        for (int i = 1; i <= 5; i++) begin
            step("starve", 0, 1, 1, 0, 0, (i < 5) ? 2'd2 : 2'd3, (i < 5) ? 3'b001 : 3'b010);
            check_cnt("starve", (i < 5) ? i : 0);
        end
        step("idle1", 0, 0, 0, 0, 0, 2'd0, 3'b000);

        for (int i = 1; i <= 4; i++) step("sat_pre", 0, 1, 1, 0, 0, 2'd2, 3'b001);
        step("sat_ret", 1, 1, 1, 0, 0, 2'd1, 3'b011);
        check_cnt("sat_ret", 4);
        step("sat_new", 0, 1, 1, 0, 0, 2'd3, 3'b010);
        check_cnt("sat_new", 0);

        step("ex_pre", 0, 1, 0, 0, 0, 2'd2, 3'b000);
        for (int i = 0; i < 3; i++) step("ex_hold", 0, 1, 0, 0, 1, 2'd2, 3'b010);
        step("ex_drop", 0, 1, 0, 0, 0, 2'd2, 3'b000);

        step("fl_rn", 1, 0, 1, 1, 0, 2'd1, 3'b001);
        step("fl_n", 0, 0, 1, 1, 0, 2'd0, 3'b001);
        step("fl_p", 0, 1, 0, 1, 0, 2'd0, 3'b010);

        step("pn1", 0, 1, 1, 0, 0, 2'd2, 3'b001);
        step("pn2", 0, 1, 1, 0, 0, 2'd2, 3'b001);
        check_cnt("pn2", 2);
        step("fl_pn", 0, 1, 1, 1, 0, 2'd0, 3'b011);
        check_cnt("fl_pn", 0);

        step("new", 0, 0, 1, 0, 0, 2'd3, 3'b000);
        step("fl_exs_new", 0, 0, 0, 1, 1, 2'd0, 3'b000);
        step("ret", 1, 0, 0, 0, 0, 2'd1, 3'b000);
        step("fl_exs_ret", 0, 0, 0, 1, 1, 2'd1, 3'b000);
        step("idle2", 0, 0, 0, 0, 0, 2'd0, 3'b000);

        step("pre_rst", 0, 1, 1, 0, 0, 2'd2, 3'b001);
        check_cnt("pre_rst", 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst.valid", 32'(o_ex_valid), 32'h0);
        check("mid_rst.src", 32'(o_ex_src), 32'h0);
        check("mid_rst.addr", o_ex_addr, 32'h0);
        check("mid_rst.stall", {29'b0, o_retire_stall, o_replay_stall, o_new_stall}, 32'h3);
        check_cnt("mid_rst", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_exp = '{valid: 1'b0, src: 2'd0, addr: 32'h0, tag: 6'h0, lq: 8'h0, chk_data: 1'b0};
        step("post_rst", 0, 0, 1, 0, 0, 2'd3, 3'b000);
        check_cnt("post_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
